// File: rtl/wb_write_slave_pkg.sv
// Shared Wishbone definitions: termination encoding, default geometry and bus-mode constants.
// Also used by the master-side write-cycle generator.
package wb_write_slave_pkg;

  typedef enum logic [1:0] {
    TermNone = 2'd0,
    TermAck  = 2'd1,
    TermRty  = 2'd2,
    TermErr  = 2'd3
  } term_e;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefAbits = 3;

  localparam bit PipedB4 = 1'b1;
  localparam bit PipedB3 = 1'b0;

  // Precedence: unmapped address beats lock, lock only refuses writes.
  function automatic term_e term_of(logic in_range, logic we, logic lock);
    if (!in_range) begin
      return TermErr;
    end else if (we && lock) begin
      return TermRty;
    end
    return TermAck;
  endfunction

endpackage

// File: rtl/wb_write_slave_if.sv
// Wishbone request/termination bundle between a master and the register-bank slave.
interface wb_write_slave_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ABITS = 3
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ABITS-1:0] adr;
  logic [WIDTH-1:0] dat_w;
  logic [WIDTH-1:0] dat_r;
  logic             ack;
  logic             wat;
  logic             rty;
  logic             err;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, wat, rty, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, wat, rty, err
  );
endinterface

// File: rtl/wb_write_slave_term_gen.sv
// Request acceptance and registered termination for the Wishbone slave, including the
// classic-mode guard against re-accepting a strobe that was already terminated.
module wb_write_slave_term_gen
  import wb_write_slave_pkg::*;
#(
  parameter bit          PIPED = PipedB4,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned ABITS = DefAbits,
  parameter int unsigned NREGS = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] adr_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             lock_i,
  output logic             commit_o,
  output term_e            term_o,
  output logic             wat_o
);

  localparam logic [ABITS:0] NRegsW = (ABITS + 1)'(NREGS);

  term_e                term_q, term_d;
  logic                 wat_q, wat_d;
  logic                 lock_q;
  logic                 hold_q, hold_d;
  logic [ABITS+WIDTH:0] req_q, req_d;
  logic [ABITS+WIDTH:0] req;
  logic                 accept;
  logic                 req_new;
  term_e                next_term;

  always_comb begin
    req       = {we_i, adr_i, dat_i};
    req_new   = !(hold_q && (req == req_q));
    next_term = term_of(({1'b0, adr_i} < NRegsW), we_i, lock_i);

    if (PIPED) begin
      accept = cyc_i & stb_i & ~wat_q;
    end else begin
      accept = cyc_i & stb_i & (term_q == TermNone) & req_new;
    end

    term_d   = accept ? next_term : TermNone;
    commit_o = accept & (next_term == TermAck);

    // Stall one cycle when lock rises inside a bus cycle so the in-flight term drains.
    wat_d = PIPED & cyc_i & lock_i & ~lock_q;

    hold_d = hold_q;
    req_d  = req_q;
    if (!(cyc_i && stb_i)) begin
      hold_d = 1'b0;
    end
    if (accept) begin
      hold_d = 1'b1;
      req_d  = req;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      term_q <= TermNone;
      wat_q  <= 1'b0;
      lock_q <= 1'b0;
      hold_q <= 1'b0;
      req_q  <= '0;
    end else begin
      term_q <= term_d;
      wat_q  <= wat_d;
      lock_q <= lock_i;
      hold_q <= hold_d;
      req_q  <= req_d;
    end
  end

  assign term_o = term_q;
  assign wat_o  = wat_q;

endmodule

// File: rtl/wb_write_slave.sv
// Wishbone slave fronting a small register bank; exposes every register and a
// one-cycle commit strobe to user logic.
module wb_write_slave
  import wb_write_slave_pkg::*;
#(
  parameter bit          PIPED = PipedB4,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned ABITS = DefAbits,
  parameter int unsigned NREGS = 6,
  parameter int unsigned DELAY = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  wb_write_slave_if.slave        bus_io,
  input  logic                   lock_i,
  output logic [NREGS*WIDTH-1:0] regs_o,
  output logic                   wr_o,
  output logic [ABITS-1:0]       wr_adr_o
);

  // Delay only matters for behavioural models of this block.
  logic unused_delay;
  assign unused_delay = ^DELAY;

  term_e            term;
  logic             commit;
  logic             wat;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] rd_data;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             wr_q, wr_d;
  logic [ABITS-1:0] wr_adr_q, wr_adr_d;

  wb_write_slave_term_gen #(
    .PIPED(PIPED),
    .WIDTH(WIDTH),
    .ABITS(ABITS),
    .NREGS(NREGS)
  ) u_term_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .cyc_i   (bus_io.cyc),
    .stb_i   (bus_io.stb),
    .we_i    (bus_io.we),
    .adr_i   (bus_io.adr),
    .dat_i   (bus_io.dat_w),
    .lock_i  (lock_i),
    .commit_o(commit),
    .term_o  (term),
    .wat_o   (wat)
  );

  always_comb begin
    wr_en   = commit & bus_io.we;
    rd_en   = commit & ~bus_io.we;
    rd_data = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_d[k] = regs_q[k];
      if (bus_io.adr == ABITS'(k)) begin
        rd_data = regs_q[k];
        if (wr_en) begin
          regs_d[k] = bus_io.dat_w;
        end
      end
    end
    dat_d    = rd_en ? rd_data : '0;
    wr_d     = wr_en;
    wr_adr_d = wr_en ? bus_io.adr : wr_adr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
      dat_q    <= '0;
      wr_q     <= 1'b0;
      wr_adr_q <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      dat_q    <= dat_d;
      wr_q     <= wr_d;
      wr_adr_q <= wr_adr_d;
    end
  end

  // A master that abandons the cycle never sees the pending termination.
  assign bus_io.ack   = bus_io.cyc & (term == TermAck);
  assign bus_io.rty   = bus_io.cyc & (term == TermRty);
  assign bus_io.err   = bus_io.cyc & (term == TermErr);
  assign bus_io.wat   = wat;
  assign bus_io.dat_r = dat_q;

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_o[k*WIDTH +: WIDTH] = regs_q[k];
    end
  end

  assign wr_o     = wr_q;
  assign wr_adr_o = wr_adr_q;

endmodule
